// File: rtl/lsu_pkg.sv
// Shared funct3 encodings, FSM states and alignment checks for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, RESP} lsu_state_t;

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        case (f3[1:0])
            2'b01:   return addr_lo[0];
            2'b10:   return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return !(f3 inside {F3_B, F3_H, F3_W});
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Purely combinational; little-endian lanes selected by the low address bits.
module lsu_align (
    input  logic [2:0]  f3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);
    logic [4:0]  b_sh;
    logic [4:0]  h_sh;
    logic [31:0] byte_w;
    logic [31:0] half_w;
    logic [31:0] mask;
    logic [31:0] ins;

    assign b_sh   = {addr_lo, 3'b000};
    assign h_sh   = {addr_lo[1], 4'b0000};
    assign byte_w = word >> b_sh;
    assign half_w = word >> h_sh;

    always_comb begin
        load_data = word;
        mask      = '1;
        ins       = wdata;
        case (f3[1:0])
            2'b00: begin
                load_data = {{24{byte_w[7] & ~f3[2]}}, byte_w[7:0]};
                mask      = 32'h0000_00FF << b_sh;
                ins       = {24'b0, wdata[7:0]} << b_sh;
            end
            2'b01: begin
                load_data = {{16{half_w[15] & ~f3[2]}}, half_w[15:0]};
                mask      = 32'h0000_FFFF << h_sh;
                ins       = {16'b0, wdata[15:0]} << h_sh;
            end
            default: ;
        endcase
    end

    // Untouched lanes keep the RAM contents so the write-back is a true merge.
    assign store_data = (word & ~mask) | (ins & mask);

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word loads and stores into aligned RAM word accesses (RMW for sub-word stores).
// Latency: error 1, word store 2, load 3, sub-word store 4 cycles; req_ready only while idle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_f3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_w_en,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);
    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        addr_lo_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              w_en_q;
    logic [DATA_W-1:0] w_data_q;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] store_data;
    logic              req_bad;

    lsu_align u_align (
        .f3         (f3_q),
        .addr_lo    (addr_lo_q),
        .word       (mem_r_data),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    assign req_ready  = (state == IDLE);
    assign req_bad    = lsu_illegal(req_we, req_f3) || lsu_misaligned(req_f3, req_addr[1:0]);
    assign mem_addr   = mem_addr_q;
    assign mem_w_data = w_data_q;
    // Combinational gate so a reset landing on the WR cycle never reaches the RAM.
    assign mem_w_en   = w_en_q & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_lo_q  <= '0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            w_en_q     <= 1'b0;
            w_data_q   <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we_q      <= req_we;
                    f3_q      <= req_f3;
                    addr_lo_q <= req_addr[1:0];
                    wdata_q   <= req_wdata;
                    if (req_bad) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else if (req_we && req_f3 == F3_W) begin
                        state      <= WR;
                        mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                        w_en_q     <= 1'b1;
                        w_data_q   <= req_wdata;
                    end else begin
                        state      <= RD;
                        mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                    end
                end
                RD: state <= WAIT;
                WAIT: begin
                    if (we_q) begin
                        state    <= WR;
                        w_en_q   <= 1'b1;
                        w_data_q <= store_data;
                    end else begin
                        state      <= RESP;
                        mem_addr_q <= '0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= load_data;
                    end
                end
                WR: begin
                    state      <= RESP;
                    mem_addr_q <= '0;
                    w_en_q     <= 1'b0;
                    w_data_q   <= '0;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word RAM model, directed plan steps and random traffic vs. a byte-level model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_f3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_w_en;
    logic [31:0] mem_w_data;
    logic [31:0] mem_r_data;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_f3     (req_f3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_w_data (mem_w_data),
        .mem_r_data (mem_r_data)
    );

    logic [31:0] ram [0:127];
    logic        pre_we = 1'b0;
    logic [6:0]  pre_idx = '0;
    logic [31:0] pre_dat = '0;

    always @(posedge clk) begin
        if (pre_we)
            ram[pre_idx] <= pre_dat;
        else if (mem_w_en)
            ram[mem_addr[8:2]] <= mem_w_data;
        mem_r_data <= ram[mem_addr[8:2]];
    end

    int          cyc = 0;
    int          wr_cnt = 0;
    int          resp_cnt = 0;
    int          wr_cyc = 0;
    int          resp_cyc = 0;
    logic [31:0] wr_addr_s = '0;
    logic [31:0] rsp_data_s = '0;
    logic        rsp_err_s = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mem_w_en === 1'b1) begin
            wr_cnt    <= wr_cnt + 1;
            wr_cyc    <= cyc;
            wr_addr_s <= mem_addr;
        end
        if (resp_valid === 1'b1) begin
            resp_cnt   <= resp_cnt + 1;
            resp_cyc   <= cyc;
            rsp_data_s <= resp_rdata;
            rsp_err_s  <= resp_err;
        end
    end

    int          checks = 0;
    int          failures = 0;
    logic [31:0] ref_mem [0:127];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int m_size(input bit [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_err(input bit we, input bit [2:0] f3, input bit [31:0] a);
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return !legal || (a % m_size(f3)) != 0;
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] w);
        int        sz;
        bit [31:0] m;
        bit [31:0] v;
        sz = m_size(f3);
        m  = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
        v  = (w >> (8 * (a % 4))) & m;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~m;
        return v;
    endfunction

    function automatic bit [31:0] m_store(input bit [2:0] f3, input bit [31:0] a,
                                          input bit [31:0] old, input bit [31:0] wd);
        bit [31:0] r;
        int        off;
        r   = old;
        off = a % 4;
        for (int i = 0; i < m_size(f3); i++) r[8*(off+i) +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic run_req(input bit we, input bit [2:0] f3, input bit [31:0] addr, input bit [31:0] wd,
                           output logic err, output logic [31:0] rdata, output int lat,
                           output int wlat, output int nresp, output int nwr, output logic [31:0] waddr);
        int t0, w0, r0;
        @(negedge clk); #1;
        check("req_ready_idle", req_ready, 1'b1);
        t0 = cyc; w0 = wr_cnt; r0 = resp_cnt;
        req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_we    = $urandom_range(0, 1);
        req_f3    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        repeat (7) @(negedge clk);
        #1;
        err   = rsp_err_s;
        rdata = rsp_data_s;
        lat   = resp_cyc - t0;
        wlat  = wr_cyc - t0;
        nresp = resp_cnt - r0;
        nwr   = wr_cnt - w0;
        waddr = wr_addr_s;
    endtask

    task automatic exec(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] addr,
                        input bit [31:0] wd, output logic [31:0] rdata);
        bit          e;
        int          idx, exp_lat, exp_nwr, exp_wlat;
        bit [31:0]   exp_rd;
        logic        err;
        logic [31:0] waddr;
        int          lat, wlat, nresp, nwr;
        e        = m_err(we, f3, addr);
        idx      = addr[8:2];
        exp_lat  = e ? 1 : (!we ? 3 : (f3 == 3'd2 ? 2 : 4));
        exp_nwr  = (e || !we) ? 0 : 1;
        exp_wlat = (f3 == 3'd2) ? 1 : 3;
        exp_rd   = (e || we) ? 32'h0 : m_load(f3, addr, ref_mem[idx]);
        if (!e && we) ref_mem[idx] = m_store(f3, addr, ref_mem[idx], wd);
        run_req(we, f3, addr, wd, err, rdata, lat, wlat, nresp, nwr, waddr);
        check({tag, "_nresp"}, nresp, 1);
        check({tag, "_err"}, err, e);
        check({tag, "_rdata"}, rdata, exp_rd);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_nwr"}, nwr, exp_nwr);
        if (exp_nwr == 1) begin
            check({tag, "_wlat"}, wlat, exp_wlat);
            check({tag, "_waddr"}, waddr, {addr[31:2], 2'b00});
        end
        check({tag, "_ram"}, ram[idx], ref_mem[idx]);
    endtask

    task automatic reset_during(input string tag, input int hold_cycles);
        int w0, r0, idx;
        idx = 7'h10;
        @(negedge clk); #1;
        w0 = wr_cnt; r0 = resp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'b000; req_addr = 32'h42; req_wdata = 32'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (hold_cycles) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check({tag, "_ready_after"}, req_ready, 1'b1);
        repeat (6) @(negedge clk);
        #1;
        check({tag, "_no_write"}, wr_cnt - w0, 0);
        check({tag, "_no_resp"}, resp_cnt - r0, 0);
        check({tag, "_ram"}, ram[idx], ref_mem[idx]);
    endtask

    initial begin
        logic [31:0] rd;
        bit          we;
        bit [2:0]    f3;
        bit [31:0]   a;

        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            pre_we  = 1'b1;
            pre_idx = 7'(i);
            pre_dat = (i == 64) ? 32'h8899_AABB : $urandom;
            ref_mem[i] = pre_dat;
        end
        @(negedge clk);
        pre_we = 1'b0;
        rst    = 1'b0;
        @(negedge clk); #1;
        check("rst_ready", req_ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_w_en", mem_w_en, 1'b0);
        check("rst_mem_w_data", mem_w_data, 32'h0);

        exec("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, rd);
        check("lb_103_const", rd, 32'hFFFF_FF88);
        exec("lbu_101", 1'b0, 3'b100, 32'h101, 32'h0, rd);
        check("lbu_101_const", rd, 32'h0000_00AA);
        exec("lh_102", 1'b0, 3'b001, 32'h102, 32'h0, rd);
        check("lh_102_const", rd, 32'hFFFF_8899);
        exec("lhu_100", 1'b0, 3'b101, 32'h100, 32'h0, rd);
        check("lhu_100_const", rd, 32'h0000_AABB);

        exec("sb_102", 1'b1, 3'b000, 32'h102, 32'h1234_5677, rd);
        check("sb_102_const", ram[64], 32'h8877_AABB);
        exec("sh_100", 1'b1, 3'b001, 32'h100, 32'h0000_CAFE, rd);
        check("sh_100_const", ram[64], 32'h8877_CAFE);
        exec("sw_104", 1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, rd);
        exec("lw_104", 1'b0, 3'b010, 32'h104, 32'h0, rd);
        check("lw_104_const", rd, 32'hDEAD_BEEF);

        exec("err_lw_102", 1'b0, 3'b010, 32'h102, 32'h0, rd);
        exec("err_sh_101", 1'b1, 3'b001, 32'h101, 32'hFFFF_FFFF, rd);
        exec("err_ld_f3_3", 1'b0, 3'b011, 32'h100, 32'h0, rd);
        exec("err_st_f3_4", 1'b1, 3'b100, 32'h100, 32'h1111_1111, rd);

        reset_during("rst_wait", 1);
        reset_during("rst_wr", 2);

        for (int n = 0; n < 40; n++) begin
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 511);
            exec("rnd", we, f3, a, $urandom, rd);
        end

        for (int i = 0; i < 128; i++)
            if (ram[i] !== ref_mem[i]) check("final_ram", ram[i], ref_mem[i]);
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the CPU's MEM stage and the word-wide data RAM.
- Converts byte, halfword and word load/store requests into aligned word accesses.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Loads return sign- or zero-extended data; misaligned or illegal requests are rejected without touching memory.

Parameters:
ADDR_W, 32, width of request and memory byte addresses
DATA_W, 32, data width; only 32 is supported

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit idle and accepting requests
req_we  input  1  1 = store, 0 = load
req_f3  input  3  RISC-V funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
req_addr  input  ADDR_W  byte address
req_wdata  input  DATA_W  store data; low byte/half used for sub-word stores
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  DATA_W  extended load data
resp_err  output  1  valid with resp_valid; misaligned or illegal f3
mem_addr  output  ADDR_W  word-aligned byte address (bits [1:0] = 0)
mem_w_en  output  1  RAM write enable
mem_w_data  output  DATA_W  RAM write word
mem_r_data  input  DATA_W  RAM read word; valid in cycle N+1 for mem_addr presented in cycle N

Behaviour:
- Reset values:
  - state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_addr=0, mem_w_en=0, mem_w_data=0.
- FSM states: IDLE, RD, WAIT, WR, RESP.
- req_ready = (state==IDLE).
  - A request is accepted on a cycle with req_valid && req_ready.
  - All req_* fields are latched on accept; they are ignored at any other time.
- Error check at accept. A request is an error when:
  - the load f3 is 011, 110 or 111; or
  - the store f3 is anything other than 000, 001 or 010; or
  - it is a halfword with addr[0]=1; or
  - it is a word with addr[1:0]!=0.
- On error: IDLE -> RESP with resp_err=1 and resp_rdata=0. No memory access occurs.
- Transitions from IDLE on accept:
  - load: -> RD
  - word store: -> WR
  - sub-word store: -> RD
- RD: drive mem_addr = {addr[ADDR_W-1:2],2'b00}, mem_w_en=0. Next state is WAIT.
- WAIT: mem_r_data is valid.
  - Load: extract the lane, extend it, register it into resp_rdata, -> RESP.
  - Sub-word store: register the merged word, -> WR.
- WR:
  - mem_w_en=1 for exactly one cycle.
  - mem_addr is the aligned address.
  - mem_w_data is req_wdata (word store) or the merged word (sub-word store).
  - Next state is RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE.
  - resp_rdata holds its value until the next RESP; it is 0 for stores.
- Latency (accept in cycle T), counted to the resp_valid cycle:
  - load: T+3
  - word store: T+2
  - sub-word store: T+4, with the write at T+3
  - error: T+1
- Lanes are little-endian; the byte lane is addr[1:0]*8 and the halfword lane is addr[1]*16.
- Loads: lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend.
- Merge: only the target byte/half lane is replaced with req_wdata[7:0] or req_wdata[15:0]; the other lanes come from mem_r_data.
- Outside RD/WAIT/WR, mem_addr, mem_w_en and mem_w_data are all 0.
- Reset mid-operation: mem_w_en is gated with !rst, so no write occurs in a cycle where rst=1. The state is IDLE on the following cycle and any in-flight request is dropped with no response.
- No back-to-back accept: req_ready is 0 during RESP.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - the state enum lsu_state_t
  - the function lsu_misaligned(f3, addr[1:0])
- One combinational sub-module, lsu_align:
  - inputs: f3, addr[1:0], word, wdata
  - outputs: extended load data and the merged store word.

Test Plan:
- RAM[0x100]=0x8899AABB; lb 0x103 -> resp_rdata=0xFFFFFF88, resp_err=0, resp_valid at T+3.
- Same word: lbu 0x101 -> 0x000000AA; lh 0x102 -> 0xFFFF8899; lhu 0x100 -> 0x0000AABB.
- sb 0x102 with wdata 0x12345677 -> single mem_w_en at T+3, RAM[0x100]=0x8877AABB, resp at T+4; sh 0x100 with 0xCAFE afterwards -> RAM=0x8877CAFE.
- sw 0x104 with 0xDEADBEEF -> mem_w_en only at T+1, mem_addr=0x104, resp at T+2; a following lw 0x104 -> 0xDEADBEEF.
- lw 0x102, sh 0x101, and a load with f3=011 -> each gives resp_err=1 and resp_rdata=0 at T+1; mem_w_en stays 0 and RAM is unchanged.
- rst=1 during WAIT of an sb -> mem_w_en never asserts, no resp_valid, req_ready=1 the cycle after rst drops, RAM unchanged.
